// File: rtl/dcache_wt_if.sv
// Bus bundle between the MEM stage, the data cache and the backing data memory.
// The slave view is the cache; the master view is the pipeline plus memory.
interface dcache_wt_if #(
    parameter int XLEN      = 32,
    parameter int ADDR_BITS = 8
) ();
    logic                   MEM_ld;
    logic                   MEM_str;
    logic                   MEM_byt;
    logic [ADDR_BITS-1:0]   MEM_addr;
    logic [XLEN-1:0]        MEM_wdata;
    logic [XLEN-1:0]        MEM_rdata;
    logic                   MEM_stall;
    logic                   D_mem_rd_req;
    logic                   D_mem_wr_req;
    logic [ADDR_BITS-1:0]   D_mem_addr;
    logic [XLEN-1:0]        D_mem_wdata;
    logic                   D_mem_byt;
    logic [4*XLEN-1:0]      D_mem_line;
    logic                   D_mem_valid;
    logic                   D_mem_wr_ack;

    modport slave (
        input  MEM_ld, MEM_str, MEM_byt, MEM_addr, MEM_wdata,
        input  D_mem_line, D_mem_valid, D_mem_wr_ack,
        output MEM_rdata, MEM_stall,
        output D_mem_rd_req, D_mem_wr_req, D_mem_addr,
        output D_mem_wdata, D_mem_byt
    );

    modport master (
        output MEM_ld, MEM_str, MEM_byt, MEM_addr, MEM_wdata,
        output D_mem_line, D_mem_valid, D_mem_wr_ack,
        input  MEM_rdata, MEM_stall,
        input  D_mem_rd_req, D_mem_wr_req, D_mem_addr,
        input  D_mem_wdata, D_mem_byt
    );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache for the MEM stage.
// 128-bit line refills, single-beat stores, combinational pipeline stall.
module dcache_wt #(
    parameter int XLEN      = 32,
    parameter int ADDR_BITS = 8,
    parameter int LINES     = 4
) (
    input  logic        clk,
    input  logic        rst,
    dcache_wt_if.slave  bus
);
    localparam int IDX = $clog2(LINES);
    localparam int TAG = ADDR_BITS - 4 - IDX;
    localparam int LW  = 4 * XLEN;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [TAG-1:0]         tag_q   [LINES];
    logic [TAG-1:0]         tag_d   [LINES];
    logic [LW-1:0]          data_q  [LINES];
    logic [LW-1:0]          data_d  [LINES];
    logic                   rd_req_q, rd_req_d;
    logic                   wr_req_q, wr_req_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]        wdata_q, wdata_d;
    logic                   byt_q, byt_d;

    logic [1:0]             bsel, wsel;
    logic [IDX-1:0]         idx, fidx;
    logic [TAG-1:0]         tag, ftag;
    logic                   hit, is_st, is_ld;
    logic [XLEN-1:0]        cur_word, new_word;
    logic [7:0]             cur_byte;

    assign bsel  = bus.MEM_addr[1:0];
    assign wsel  = bus.MEM_addr[3:2];
    assign idx   = bus.MEM_addr[3+IDX:4];
    assign tag   = bus.MEM_addr[ADDR_BITS-1:4+IDX];
    // Refill target comes from the latched request, not the live bus.
    assign fidx  = addr_q[3+IDX:4];
    assign ftag  = addr_q[ADDR_BITS-1:4+IDX];

    assign is_st = bus.MEM_str;
    assign is_ld = bus.MEM_ld & ~bus.MEM_str;
    assign hit   = valid_q[idx] && (tag_q[idx] == tag);

    assign cur_word = data_q[idx][32*wsel +: 32];
    assign cur_byte = cur_word[8*bsel +: 8];

    always_comb begin
        new_word = bus.MEM_wdata;
        if (bus.MEM_byt) begin
            new_word = cur_word;
            new_word[8*bsel +: 8] = bus.MEM_wdata[7:0];
        end
    end

    always_comb begin
        bus.MEM_rdata = '0;
        if (rst) begin
            bus.MEM_rdata = bus.MEM_byt ?
                {{(XLEN-8){1'b0}}, cur_byte} : cur_word;
        end
    end

    always_comb begin
        bus.MEM_stall = 1'b0;
        if (rst) begin
            unique case (state_q)
                IDLE:          bus.MEM_stall = is_st | (is_ld & ~hit);
                REFILL, WRITE: bus.MEM_stall = 1'b1;
                DONE:          bus.MEM_stall = 1'b0;
                default:       bus.MEM_stall = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        data_d   = data_q;
        rd_req_d = rd_req_q;
        wr_req_d = wr_req_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        byt_d    = byt_q;
        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    is_st: begin
                        state_d  = WRITE;
                        wr_req_d = 1'b1;
                        addr_d   = bus.MEM_addr;
                        wdata_d  = bus.MEM_wdata;
                        byt_d    = bus.MEM_byt;
                        if (hit) data_d[idx][32*wsel +: 32] = new_word;
                    end
                    (is_ld & ~hit): begin
                        state_d  = REFILL;
                        rd_req_d = 1'b1;
                        addr_d   = {bus.MEM_addr[ADDR_BITS-1:4], 4'b0};
                    end
                    default: ;
                endcase
            end
            REFILL: begin
                if (bus.D_mem_valid) begin
                    data_d[fidx]  = bus.D_mem_line;
                    valid_d[fidx] = 1'b1;
                    tag_d[fidx]   = ftag;
                    rd_req_d      = 1'b0;
                    state_d       = IDLE;
                end
            end
            WRITE: begin
                if (bus.D_mem_wr_ack) begin
                    wr_req_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            byt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            rd_req_q <= rd_req_d;
            wr_req_q <= wr_req_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            byt_q    <= byt_d;
        end
    end

    assign bus.D_mem_rd_req = rd_req_q;
    assign bus.D_mem_wr_req = wr_req_q;
    assign bus.D_mem_addr   = addr_q;
    assign bus.D_mem_wdata  = wdata_q;
    assign bus.D_mem_byt    = byt_q;
endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: vector table of loads/stores plus
// hand sequences for reset, reset mid-refill and stray memory pulses.
module tb_dcache_wt;
    localparam int L = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dcache_wt_if #(.XLEN(32), .ADDR_BITS(8)) bus ();

    dcache_wt #(.XLEN(32), .ADDR_BITS(8), .LINES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int ncmp = 0;
    int nbad = 0;

    logic [7:0] mem [256];
    bit bk_en = 1'b1;
    bit stray = 1'b0;

    typedef struct {
        logic        ld;
        logic        st;
        logic        byt;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          stalls;
        logic [31:0] rdata;
        bit          chk_rd;
        bit          rdreq;
    } vec_t;

    vec_t tv[18];

    function automatic vec_t mk(logic ld, logic st, logic byt,
                                logic [7:0] a, logic [31:0] wd,
                                int s, logic [31:0] rd, bit cr, bit rq);
        vec_t v;
        v.ld = ld; v.st = st; v.byt = byt; v.addr = a; v.wdata = wd;
        v.stalls = s; v.rdata = rd; v.chk_rd = cr; v.rdreq = rq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic put_word(input logic [7:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + 8'(i)] = w[8*i +: 8];
    endtask

    // Backing memory: answers rd/wr requests on the L-th cycle they are held.
    initial begin
        int rcnt, wcnt;
        logic [7:0] a;
        rcnt = 0;
        wcnt = 0;
        bus.D_mem_valid  = 1'b0;
        bus.D_mem_wr_ack = 1'b0;
        bus.D_mem_line   = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.D_mem_valid  = stray;
            bus.D_mem_wr_ack = stray;
            bus.D_mem_line   = stray ? {4{32'hEEEE_EEEE}} : '0;
            if (!rst || !bk_en) begin
                rcnt = 0;
                wcnt = 0;
            end else begin
                if (bus.D_mem_rd_req) begin
                    rcnt++;
                    if (rcnt == L) begin
                        rcnt = 0;
                        bus.D_mem_valid = 1'b1;
                        for (int i = 0; i < 16; i++) begin
                            a = {bus.D_mem_addr[7:4], 4'(i)};
                            bus.D_mem_line[8*i +: 8] = mem[a];
                        end
                    end
                end else rcnt = 0;
                if (bus.D_mem_wr_req) begin
                    wcnt++;
                    if (wcnt == L) begin
                        wcnt = 0;
                        bus.D_mem_wr_ack = 1'b1;
                        a = bus.D_mem_addr;
                        if (bus.D_mem_byt) mem[a] = bus.D_mem_wdata[7:0];
                        else put_word({a[7:2], 2'b0}, bus.D_mem_wdata);
                    end
                end else wcnt = 0;
            end
        end
    end

    // Issue one request and hold it until the stall drops.
    task automatic do_op(input logic ld, input logic st, input logic byt,
                         input logic [7:0] a, input logic [31:0] wd,
                         output int stalls, output logic [31:0] rd,
                         output bit saw_rd, output bit saw_wr,
                         output bit bad_bus);
        stalls = 0;
        saw_rd = 0;
        saw_wr = 0;
        bad_bus = 0;
        rd = '0;
        bus.MEM_ld = ld;
        bus.MEM_str = st;
        bus.MEM_byt = byt;
        bus.MEM_addr = a;
        bus.MEM_wdata = wd;
        forever begin
            @(negedge clk);
            if (bus.D_mem_rd_req) begin
                saw_rd = 1;
                if (bus.D_mem_addr !== {a[7:4], 4'b0}) bad_bus = 1;
            end
            if (bus.D_mem_wr_req) begin
                saw_wr = 1;
                if (bus.D_mem_addr !== a || bus.D_mem_byt !== byt ||
                    bus.D_mem_wdata !== wd) bad_bus = 1;
            end
            if (!bus.MEM_stall) begin
                rd = bus.MEM_rdata;
                break;
            end
            stalls++;
            if (stalls > 40) begin
                $display("FAIL timeout: stall held %0d cycles at addr %h",
                         stalls, a);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.MEM_ld = 1'b0;
        bus.MEM_str = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int s;
        logic [31:0] rd;
        bit srd, swr, bad;
        do_op(v.ld, v.st, v.byt, v.addr, v.wdata, s, rd, srd, swr, bad);
        chk({tag, " stall_cycles"}, s, v.stalls);
        chk({tag, " rd_req_seen"}, {31'b0, srd}, {31'b0, v.rdreq});
        chk({tag, " wr_req_seen"}, {31'b0, swr}, {31'b0, v.st});
        chk({tag, " mem_bus_fields"}, {31'b0, bad}, 32'd0);
        if (v.chk_rd) chk({tag, " rdata"}, rd, v.rdata);
    endtask

    initial begin
        for (int i = 0; i < 256; i += 4)
            put_word(8'(i), 32'hD000_0000 | 32'(i));
        put_word(8'h20, 32'h11);
        put_word(8'h24, 32'h22);
        put_word(8'h28, 32'h33);
        put_word(8'h2C, 32'h44);

        tv[0]  = mk(1, 0, 0, 8'h24, 0, 3, 32'h0000_0022, 1, 1);
        tv[1]  = mk(1, 0, 0, 8'h28, 0, 0, 32'h0000_0033, 1, 0);
        tv[2]  = mk(0, 1, 1, 8'h25, 32'hAB, 3, 0, 0, 0);
        tv[3]  = mk(1, 0, 1, 8'h25, 0, 0, 32'h0000_00AB, 1, 0);
        tv[4]  = mk(1, 0, 0, 8'h24, 0, 0, 32'h0000_AB22, 1, 0);
        tv[5]  = mk(0, 1, 0, 8'h64, 32'hCAFE_F00D, 3, 0, 0, 0);
        tv[6]  = mk(1, 0, 0, 8'h64, 0, 3, 32'hCAFE_F00D, 1, 1);
        tv[7]  = mk(1, 0, 0, 8'h04, 0, 3, 32'hD000_0004, 1, 1);
        tv[8]  = mk(1, 0, 0, 8'h44, 0, 3, 32'hD000_0044, 1, 1);
        tv[9]  = mk(1, 0, 0, 8'h04, 0, 3, 32'hD000_0004, 1, 1);
        tv[10] = mk(1, 0, 0, 8'h24, 0, 3, 32'h0000_AB22, 1, 1);
        tv[11] = mk(1, 1, 0, 8'h28, 32'h1234_5678, 3, 0, 0, 0);
        tv[12] = mk(1, 0, 0, 8'h28, 0, 0, 32'h1234_5678, 1, 0);
        tv[13] = mk(1, 0, 1, 8'h2B, 0, 0, 32'h0000_0012, 1, 0);
        tv[14] = mk(1, 0, 1, 8'h66, 0, 3, 32'h0000_00FE, 1, 1);
        tv[15] = mk(0, 1, 1, 8'h2A, 32'hFFFF_FF5A, 3, 0, 0, 0);
        tv[16] = mk(1, 0, 0, 8'h28, 0, 3, 32'h125A_5678, 1, 1);
        tv[17] = mk(1, 0, 0, 8'h2C, 0, 0, 32'h0000_0044, 1, 0);

        // Request held during reset must not stall or return data.
        bus.MEM_ld = 1'b1;
        bus.MEM_str = 1'b0;
        bus.MEM_byt = 1'b0;
        bus.MEM_addr = 8'h24;
        bus.MEM_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset stall", {31'b0, bus.MEM_stall}, 32'd0);
        chk("reset rdata", bus.MEM_rdata, 32'd0);
        chk("reset rd_req", {31'b0, bus.D_mem_rd_req}, 32'd0);
        chk("reset wr_req", {31'b0, bus.D_mem_wr_req}, 32'd0);
        chk("reset d_addr", {24'b0, bus.D_mem_addr}, 32'd0);
        chk("reset d_wdata", bus.D_mem_wdata, 32'd0);
        chk("reset d_byt", {31'b0, bus.D_mem_byt}, 32'd0);
        bus.MEM_ld = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) run_vec(tv[i], $sformatf("vec%0d", i));

        // Reset in the middle of a refill that memory never answers.
        bk_en = 1'b0;
        bus.MEM_ld = 1'b1;
        bus.MEM_addr = 8'h88;
        bus.MEM_byt = 1'b0;
        @(negedge clk);
        chk("miss stall cycle0", {31'b0, bus.MEM_stall}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("refill rd_req", {31'b0, bus.D_mem_rd_req}, 32'd1);
        chk("refill addr", {24'b0, bus.D_mem_addr}, 32'h80);
        rst = 1'b0;
        bus.MEM_ld = 1'b0;
        @(negedge clk);
        chk("mid-refill reset rd_req", {31'b0, bus.D_mem_rd_req}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post-reset idle stall", {31'b0, bus.MEM_stall}, 32'd0);
        @(posedge clk);
        #1;
        stray = 1'b1;
        @(posedge clk);
        #1;
        stray = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("stray pulse rd_req", {31'b0, bus.D_mem_rd_req}, 32'd0);
        chk("stray pulse wr_req", {31'b0, bus.D_mem_wr_req}, 32'd0);
        bk_en = 1'b1;
        run_vec(mk(1, 0, 0, 8'h88, 0, 3, 32'hD000_0088, 1, 1), "rst_reload");
        run_vec(mk(1, 0, 0, 8'h28, 0, 3, 32'h125A_5678, 1, 1), "rst_inval");
        run_vec(mk(1, 0, 0, 8'h28, 0, 0, 32'h125A_5678, 1, 0), "rst_hit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
